// File: rtl/window_seq_pkg.sv
// Shared types for the window frame sequencer: FSM states, the datapath tag
// word that travels alongside each sample, and the address-width helper.
package window_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Marker word carried through the datapath-latency pipe with each sample
   typedef struct packed {
      logic valid;
      logic sof;
      logic eof;
   } tag_t;

   localparam tag_t TAG_NONE = '0;

   // Coefficient ROM address width for a window of n samples
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/window_seq_if.sv
// Sample-stream and datapath-control bundle between the sequencer (slave side
// of the sample stream, driver of the datapath controls) and its surroundings.
interface window_seq_if #(
   parameter int ADDR_W = 10
);
   logic              s_valid;
   logic              s_ready;
   logic              dp_en;
   logic [ADDR_W-1:0] coeff_addr;
   logic              m_valid;
   logic              m_sof;
   logic              m_eof;

   // Environment: sample source plus datapath/downstream consumer
   modport master (
      output s_valid,
      input  s_ready, dp_en, coeff_addr, m_valid, m_sof, m_eof
   );

   // Sequencer
   modport slave (
      input  s_valid,
      output s_ready, dp_en, coeff_addr, m_valid, m_sof, m_eof
   );
endinterface

// File: rtl/window_seq_tag_pipe.sv
// Enable-gated LATENCY-deep shift register for the {valid,sof,eof} tags, so the
// markers line up with the window multiplier output. Synchronous clear drops
// every tag in flight (used when a run is cancelled).
module window_tag_pipe
   import window_seq_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t stage_q [LATENCY];

   // Advance one slot per datapath enable; clear takes priority over a shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) stage_q[i] <= TAG_NONE;
      end else if (clr_i) begin
         for (int i = 0; i < LATENCY; i++) stage_q[i] <= TAG_NONE;
      end else if (en_i) begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/window_seq.sv
// Frame sequencer for the window multiplier: gates the sample stream into
// frames of N samples, walks the coefficient ROM address, runs the programmed
// number of frames, flushes the datapath pipeline and tags its output words.
module window_seq
   import window_seq_pkg::*;
#(
   parameter int N       = 1024,
   parameter int LATENCY = 2,
   parameter int FRAME_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [FRAME_W-1:0] cfg_frames_i,
   window_seq_if.slave        bus,
   output logic [FRAME_W-1:0] frame_idx_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int ADDR_W = addr_w(N);
   localparam int CNT_W  = $clog2(LATENCY + 1);

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  addr_d;
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_d;
   logic [FRAME_W-1:0] cfg_q;
   logic [CNT_W-1:0]   drain_q;
   logic               done_q;

   logic dp_en;
   logic last_addr;
   logic last_frame;
   tag_t tag_in;
   tag_t tag_out;

   // In RUN the datapath follows the sample stream; in DRAIN it free-runs to flush
   assign dp_en      = ((state_q == ST_RUN) && bus.s_valid) || (state_q == ST_DRAIN);
   assign last_addr  = (addr_q == ADDR_W'(N - 1));
   assign last_frame = (frame_q == (cfg_q - FRAME_W'(1)));
   assign addr_d     = last_addr ? '0 : addr_q + 1'b1;
   assign frame_d    = frame_q + 1'b1;

   // Sequencer FSM with its address, frame and drain counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         frame_q <= '0;
         cfg_q   <= '0;
         drain_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            frame_q <= '0;
            drain_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     if (cfg_frames_i != '0) begin
                        cfg_q   <= cfg_frames_i;
                        state_q <= ST_RUN;
                     end else begin
                        // Empty run completes immediately
                        done_q <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (dp_en) begin
                     addr_q <= addr_d;
                     if (last_addr) begin
                        frame_q <= frame_d;
                        if (last_frame) begin
                           state_q <= ST_DRAIN;
                           drain_q <= CNT_W'(LATENCY);
                        end
                     end
                  end
               end
               ST_DRAIN: begin
                  drain_q <= drain_q - 1'b1;
                  if (drain_q == CNT_W'(1)) begin
                     state_q <= ST_IDLE;
                     frame_q <= '0;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Real samples enter tagged with their frame position; drain pushes bubbles
   always_comb begin
      tag_in = TAG_NONE;
      if (state_q == ST_RUN) begin
         tag_in.valid = 1'b1;
         tag_in.sof   = (addr_q == '0);
         tag_in.eof   = last_addr;
      end
   end

   window_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .en_i  (dp_en),
      .clr_i (abort_i),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   assign bus.s_ready    = (state_q == ST_RUN) && bus.s_valid;
   assign bus.dp_en      = dp_en;
   assign bus.coeff_addr = addr_q;
   // A datapath word only exists on cycles the datapath advances
   assign bus.m_valid    = tag_out.valid & dp_en;
   assign bus.m_sof      = tag_out.sof   & dp_en;
   assign bus.m_eof      = tag_out.eof   & dp_en;

   assign frame_idx_o = frame_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_window_seq.sv
// Directed bench for window_seq with N=8, LATENCY=2, FRAME_W=4.
module tb_window_seq;
   import window_seq_pkg::*;

   localparam int N   = 8;
   localparam int LAT = 2;
   localparam int FW  = 4;
   localparam int AW  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          abort_i;
   logic [FW-1:0] cfg_i;
   logic [FW-1:0] frame_idx_o;
   logic          busy_o;
   logic          done_o;

   int errors = 0;
   int checks = 0;

   window_seq_if #(.ADDR_W(AW)) bus ();

   window_seq #(
      .N       (N),
      .LATENCY (LAT),
      .FRAME_W (FW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .cfg_frames_i (cfg_i),
      .bus          (bus),
      .frame_idx_o  (frame_idx_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  busy_o,         0);
      chk({tag, "_dpen"},  bus.dp_en,      0);
      chk({tag, "_addr"},  bus.coeff_addr, 0);
      chk({tag, "_frame"}, frame_idx_o,    0);
      chk({tag, "_mval"},  bus.m_valid,    0);
   endtask

   // One full run of `frames` frames; gap=1 alternates s_valid 1,0,1,0.
   // restart=1 pulses start mid-run; cfg is changed while busy in every run.
   task automatic run_frames(input int frames, input bit gap, input bit restart, input string nm);
      int k     = 0;
      int c     = 0;
      int w;
      int total = frames * N;
      int tot_v = 0;
      int tot_s = 0;
      int tot_e = 0;
      bit sv;
      bit ev;
      @(negedge clk);
      start_i = 1'b1; cfg_i = FW'(frames); bus.s_valid = 1'b0;
      #1 chk({nm, "_startcyc_busy"}, busy_o, 0);
      @(negedge clk);
      start_i = 1'b0; cfg_i = FW'(frames + 1);
      while (k < total) begin
         sv = gap ? (c % 2 == 0) : 1'b1;
         bus.s_valid = sv;
         start_i = (restart && c == 5);
         #1;
         w  = k - LAT;
         ev = sv && (w >= 0);
         chk({nm, "_dpen"},  bus.dp_en,      sv);
         chk({nm, "_rdy"},   bus.s_ready,    sv);
         chk({nm, "_addr"},  bus.coeff_addr, k % N);
         chk({nm, "_frame"}, frame_idx_o,    k / N);
         chk({nm, "_busy"},  busy_o,         1);
         chk({nm, "_done"},  done_o,         0);
         chk({nm, "_mval"},  bus.m_valid,    ev);
         chk({nm, "_msof"},  bus.m_sof,      ev && (w % N == 0));
         chk({nm, "_meof"},  bus.m_eof,      ev && (w % N == N - 1));
         tot_v += int'(bus.m_valid);
         tot_s += int'(bus.m_sof);
         tot_e += int'(bus.m_eof);
         if (sv) k++;
         c++;
         @(negedge clk);
      end
      start_i = 1'b0;
      for (int d = 0; d < LAT; d++) begin
         bus.s_valid = 1'b0;
         #1;
         w = total - LAT + d;
         chk({nm, "_drain_dpen"},  bus.dp_en,      1);
         chk({nm, "_drain_rdy"},   bus.s_ready,    0);
         chk({nm, "_drain_busy"},  busy_o,         1);
         chk({nm, "_drain_done"},  done_o,         0);
         chk({nm, "_drain_addr"},  bus.coeff_addr, 0);
         chk({nm, "_drain_frame"}, frame_idx_o,    frames);
         chk({nm, "_drain_mval"},  bus.m_valid,    1);
         chk({nm, "_drain_msof"},  bus.m_sof,      (w % N == 0));
         chk({nm, "_drain_meof"},  bus.m_eof,      (w % N == N - 1));
         tot_v += int'(bus.m_valid);
         tot_s += int'(bus.m_sof);
         tot_e += int'(bus.m_eof);
         @(negedge clk);
      end
      #1;
      chk({nm, "_done_pulse"}, done_o, 1);
      chk_idle({nm, "_end"});
      @(negedge clk);
      #1 chk({nm, "_done_gone"}, done_o, 0);
      chk({nm, "_tot_valid"}, tot_v, total);
      chk({nm, "_tot_sof"},   tot_s, frames);
      chk({nm, "_tot_eof"},   tot_e, frames);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_i = '0; bus.s_valid = 1'b0;
      #12;
      chk_idle("reset");
      chk("reset_done", done_o, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: two frames, continuous samples
      run_frames(2, 1'b0, 1'b0, "s1");

      // 2: same run with gaps between samples
      run_frames(2, 1'b1, 1'b0, "s2");

      // 3: zero-frame run
      @(negedge clk);
      start_i = 1'b1; cfg_i = '0; bus.s_valid = 1'b1;
      #1 chk("s3_busy0", busy_o, 0);
      chk("s3_dpen0", bus.dp_en, 0);
      @(negedge clk);
      start_i = 1'b0;
      #1 chk("s3_done", done_o, 1);
      chk("s3_busy1", busy_o, 0);
      chk("s3_dpen1", bus.dp_en, 0);
      @(negedge clk);
      bus.s_valid = 1'b0;
      #1 chk("s3_done_gone", done_o, 0);

      // 4: abort at address 5 of frame 0, then a clean run
      @(negedge clk);
      start_i = 1'b1; cfg_i = 4'd3; bus.s_valid = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      #1 chk("s4_addr5", bus.coeff_addr, 5);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      #1 chk_idle("s4_abort");
      chk("s4_nodone0", done_o, 0);
      @(negedge clk);
      #1 chk("s4_nodone1", done_o, 0);
      run_frames(1, 1'b0, 1'b0, "s4");

      // 5: start+abort together stays idle; start during a run is ignored
      @(negedge clk);
      start_i = 1'b1; abort_i = 1'b1; cfg_i = 4'd2; bus.s_valid = 1'b1;
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0; bus.s_valid = 1'b0;
      #1 chk_idle("s5_both");
      chk("s5_done", done_o, 0);
      run_frames(2, 1'b0, 1'b1, "s5");

      // 6: asynchronous reset mid-frame, then a normal run
      @(negedge clk);
      start_i = 1'b1; cfg_i = 4'd2; bus.s_valid = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("s6_addr3", bus.coeff_addr, 3);
      chk("s6_mval_pre", bus.m_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk_idle("s6_rst");
      chk("s6_rdy", bus.s_ready, 0);
      chk("s6_done", done_o, 0);
      @(negedge clk);
      rst = 1'b0; bus.s_valid = 1'b0;
      run_frames(1, 1'b0, 1'b0, "s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
